regfile_writeback: RTL and testbench

Write-back stage that drives the write port (`we`/`wa`/`wd`) of the 8 x 16-bit core register file. It merges two result sources into the single register-file write port: single-cycle ALU results and in-order load responses from data memory. It tracks destination registers of outstanding loads in a small tag FIFO and exports a per-register pending scoreboard so decode can stall on RAW hazards. Register 0 is owned by the PC path, so every write addressed to register 0 is suppressed here.

---
 rtl/regfile_writeback.sv | 133 +++++++++++++
 tb/tb_regfile_writeback.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and in-order load responses onto the
// single register-file write port. A small tag FIFO remembers where each
// outstanding load will land, and a per-register pending vector lets decode
// stall on RAW hazards. Writes to register 0 are swallowed because that
// register belongs to the PC path.
module regfile_writeback #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int LD_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_alu_valid,
    output logic                   o_alu_ready,
    input  logic [ADDR_W-1:0]      i_alu_wa,
    input  logic [DATA_W-1:0]      i_alu_wd,
    input  logic                   i_ld_req_valid,
    output logic                   o_ld_req_ready,
    input  logic [ADDR_W-1:0]      i_ld_req_wa,
    input  logic                   i_ld_rsp_valid,
    input  logic [DATA_W-1:0]      i_ld_rsp_wd,
    output logic                   o_we,
    output logic [ADDR_W-1:0]      o_wa,
    output logic [DATA_W-1:0]      o_wd,
    output logic [(1<<ADDR_W)-1:0] o_pending,
    output logic [ADDR_W-1:0]      o_ld_count,
    output logic                   o_rsp_err
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CNT_W = $clog2(LD_DEPTH + 1);

    logic [ADDR_W-1:0] r_tags [LD_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wd;
    logic              r_rsp_err;

    logic              w_push;
    logic              w_pop;
    logic              w_alu_fire;
    logic [ADDR_W-1:0] w_head;
    logic [NREG-1:0]   w_pending;
    logic [PTR_W-1:0]  w_off   [LD_DEPTH];
    logic              w_entry_valid [LD_DEPTH];

    assign w_head         = r_tags[r_rd_ptr];
    assign o_ld_req_ready = (r_count != CNT_W'(LD_DEPTH));
    assign w_push         = i_ld_req_valid && o_ld_req_ready;
    assign w_pop          = i_ld_rsp_valid && (r_count != '0);
    assign o_alu_ready    = !w_pop && !w_pending[i_alu_wa];
    assign w_alu_fire     = i_alu_valid && o_alu_ready;

    // A slot is live when its distance from the read pointer is below the count
    for (genvar g = 0; g < LD_DEPTH; g++) begin : g_entry
        assign w_off[g]         = PTR_W'(g) - r_rd_ptr;
        assign w_entry_valid[g] = (CNT_W'(w_off[g]) < r_count);
    end

    // Scoreboard: OR together the destinations of every live tag, r0 never pends
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_pending[r_tags[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    // Tag FIFO bookkeeping, sticky error flag and the registered write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                r_tags[i] <= '0;
            end
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= i_ld_req_wa;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_ld_rsp_valid && (r_count == '0)) begin
                r_rsp_err <= 1'b1;
            end
            if (w_pop) begin
                if (w_head != '0) begin
                    r_we <= 1'b1;
                    r_wa <= w_head;
                    r_wd <= i_ld_rsp_wd;
                end else begin
                    r_we <= 1'b0;
                end
            end else if (w_alu_fire) begin
                if (i_alu_wa != '0) begin
                    r_we <= 1'b1;
                    r_wa <= i_alu_wa;
                    r_wd <= i_alu_wd;
                end else begin
                    r_we <= 1'b0;
                end
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign o_we       = r_we;
    assign o_wa       = r_wa;
    assign o_wd       = r_wd;
    assign o_pending  = w_pending;
    assign o_ld_count = ADDR_W'(r_count);
    assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: drives directed scenarios and random traffic into
// regfile_writeback and compares every output against a queue-based model.
module tb_regfile_writeback;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int LD_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              aluValid;
    logic              aluReady;
    logic [ADDR_W-1:0] aluWa;
    logic [DATA_W-1:0] aluWd;
    logic              reqValid;
    logic              reqReady;
    logic [ADDR_W-1:0] reqWa;
    logic              rspValid;
    logic [DATA_W-1:0] rspWd;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [7:0]        pending;
    logic [ADDR_W-1:0] ldCount;
    logic              rspErr;

    int total = 0;
    int bad   = 0;

    // Reference model state: queue of outstanding load destinations in order
    int          tagQ[$];
    logic        expWe  = 1'b0;
    logic [2:0]  expWa  = '0;
    logic [15:0] expWd  = '0;
    logic        expErr = 1'b0;

    regfile_writeback #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LD_DEPTH(LD_DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alu_valid   (aluValid),
        .o_alu_ready   (aluReady),
        .i_alu_wa      (aluWa),
        .i_alu_wd      (aluWd),
        .i_ld_req_valid(reqValid),
        .o_ld_req_ready(reqReady),
        .i_ld_req_wa   (reqWa),
        .i_ld_rsp_valid(rspValid),
        .i_ld_rsp_wd   (rspWd),
        .o_we          (we),
        .o_wa          (wa),
        .o_wd          (wd),
        .o_pending     (pending),
        .o_ld_count    (ldCount),
        .o_rsp_err     (rspErr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: drive at negedge, check combinational outputs,
    // advance the model, then check registered outputs just after posedge
    task automatic applyStimulus(input bit iRst, input bit iAluV, input int iAluWa,
                                 input int iAluWd, input bit iReqV, input int iReqWa,
                                 input bit iRspV, input int iRspWd);
        logic [7:0] expPending;
        int         sizeNow;
        int         head;
        bit         popNow;
        bit         expAluReady;
        bit         expReqReady;
        @(negedge clk);
        rst      = iRst;
        aluValid = iAluV;
        aluWa    = 3'(iAluWa);
        aluWd    = 16'(iAluWd);
        reqValid = iReqV;
        reqWa    = 3'(iReqWa);
        rspValid = iRspV;
        rspWd    = 16'(iRspWd);

        expPending = '0;
        foreach (tagQ[k]) begin
            if (tagQ[k] != 0) expPending[tagQ[k]] = 1'b1;
        end
        sizeNow     = tagQ.size();
        expReqReady = (sizeNow != LD_DEPTH);
        popNow      = iRspV && (sizeNow > 0);
        expAluReady = !popNow && !expPending[iAluWa & 7];

        #1;
        checkOutput("pending",      32'(pending),  32'(expPending));
        checkOutput("ld_count",     32'(ldCount),  32'(sizeNow));
        checkOutput("ld_req_ready", 32'(reqReady), 32'(expReqReady));
        checkOutput("alu_ready",    32'(aluReady), 32'(expAluReady));

        if (iRst) begin
            tagQ.delete();
            expWe  = 1'b0;
            expWa  = '0;
            expWd  = '0;
            expErr = 1'b0;
        end else begin
            if (iRspV && sizeNow == 0) expErr = 1'b1;
            if (popNow) begin
                head = tagQ.pop_front();
                if (head != 0) begin
                    expWe = 1'b1;
                    expWa = 3'(head);
                    expWd = 16'(iRspWd);
                end else begin
                    expWe = 1'b0;
                end
            end else if (iAluV && expAluReady) begin
                if ((iAluWa & 7) != 0) begin
                    expWe = 1'b1;
                    expWa = 3'(iAluWa);
                    expWd = 16'(iAluWd);
                end else begin
                    expWe = 1'b0;
                end
            end else begin
                expWe = 1'b0;
            end
            if (iReqV && expReqReady) tagQ.push_back(iReqWa & 7);
        end

        @(posedge clk);
        #1;
        checkOutput("we",      32'(we),     32'(expWe));
        checkOutput("wa",      32'(wa),     32'(expWa));
        checkOutput("wd",      32'(wd),     32'(expWd));
        checkOutput("rsp_err", 32'(rspErr), 32'(expErr));
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Main sequence: directed scenarios, then randomized traffic
    initial begin
        rst = 1'b1; aluValid = 0; aluWa = 0; aluWd = 0;
        reqValid = 0; reqWa = 0; rspValid = 0; rspWd = 0;
        repeat (2) @(posedge clk);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_ld_req_ready", 32'(reqReady), 32'd1);
        checkOutput("reset_pending",      32'(pending),  32'd0);
        checkOutput("reset_we",           32'(we),       32'd0);

        // ALU only
        applyStimulus(0, 1, 3, 'hBEEF, 0, 0, 0, 0);
        checkOutput("alu_beef_wd", 32'(wd), 32'hBEEF);
        idle();

        // Load round trip
        applyStimulus(0, 0, 0, 0, 1, 5, 0, 0);
        checkOutput("load_pending5", 32'(pending[5]), 32'd1);
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 'h1234);
        checkOutput("load_wd", 32'(wd), 32'h1234);
        idle();

        // Collision between load response and ALU
        applyStimulus(0, 0, 0, 0, 1, 2, 0, 0);
        idle();
        applyStimulus(0, 1, 4, 'h4444, 0, 0, 1, 'h2222);
        applyStimulus(0, 1, 4, 'h4444, 0, 0, 0, 0);
        idle();

        // Full FIFO and WAW hold on r1
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 6, 0, 0);
        checkOutput("full_ld_count", 32'(ldCount), 32'd4);
        applyStimulus(0, 1, 1, 'hAAAA, 1, 7, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 'hAAAA, 0, 0, 1, 'h100 + i);
        applyStimulus(0, 1, 1, 'hAAAA, 0, 0, 0, 0);
        idle();

        // Register 0 suppression and stray response error
        applyStimulus(0, 1, 0, 'h5555, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 'h6666);
        idle();
        checkOutput("err_sticky", 32'(rspErr), 32'd1);

        // Reset with loads in flight
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, i + 3, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 'h7777);
        idle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit rRst;
            bit rRsp;
            rRst = ($urandom_range(0, 99) < 2);
            if (tagQ.size() > 0) rRsp = ($urandom_range(0, 99) < 40);
            else                 rRsp = ($urandom_range(0, 99) < 3);
            applyStimulus(rRst, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                          $urandom_range(0, 65535), $urandom_range(0, 9) < 4,
                          $urandom_range(0, 7), rRsp, $urandom_range(0, 65535));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
